// File: rtl/press_pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// press_pulse_stretcher_pkg
//   Shared definitions for the press pulse stretcher:
//   - state_t : FSM state encoding (ST_IDLE, ST_HOLD, ST_GAP)
//   - DEFAULT_HOLD_CYCLES / DEFAULT_GAP_CYCLES : 10 ms at 100 MHz, the same
//     figures the button debouncer uses, so emulated presses look like real
//     ones to the debounce path.
// -----------------------------------------------------------------------------
package press_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_HOLD_CYCLES = 1_000_000;
  localparam int DEFAULT_GAP_CYCLES  = 1_000_000;
  localparam int DEFAULT_PEND_W      = 4;

endpackage

// File: rtl/press_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// press_pulse_stretcher
//   Turns single-cycle press events into a button-like waveform: o_level high
//   for HOLD_CYCLES, then low for at least GAP_CYCLES. Presses that arrive
//   while a pulse is in progress are queued in a saturating counter.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high, dominates all inputs
//   i_press      press event; each cycle it is high counts as one event
//   o_level      stretched button level (high in HOLD)
//   o_busy       high in HOLD or GAP
//   o_pending    queued events not yet started
//   o_overflow   one-cycle pulse: an event was dropped (queue full)
//   o_dbg_state  current FSM state (state_t encoding), for debug/checkers
//
// Event semantics: i_press has no back-pressure. Every cycle it is high is
// either started immediately, queued, or (queue full) dropped with
// o_overflow flagged on the following cycle.
// -----------------------------------------------------------------------------
module press_pulse_stretcher
  import press_pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int PEND_W      = DEFAULT_PEND_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_press,
  output logic              o_level,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow,
  output logic [1:0]        o_dbg_state
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0]     HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t              r_state;
  logic [TW-1:0]       r_timer;
  logic [PEND_W-1:0]   r_pending;
  logic                r_level;
  logic                r_busy;
  logic                r_overflow;

  state_t              w_state_nxt;
  logic [TW-1:0]       w_timer_nxt;
  logic [PEND_W-1:0]   w_pend_nxt;
  logic                w_take_press;  // this cycle's i_press starts a pulse directly
  logic                w_take_pend;   // a queued event starts a pulse
  logic                w_add;         // i_press must go to the queue
  logic                w_drop;        // i_press lost because the queue is full

  // Next-state / timer decode
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_take_press = 1'b0;
    w_take_pend  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (i_press) begin
          w_take_press = 1'b1;
          w_state_nxt  = ST_HOLD;
        end else if (r_pending != '0) begin
          w_take_pend  = 1'b1;
          w_state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_timer == HOLD_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_GAP;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_GAP: begin
        if (r_timer == GAP_LAST) begin
          w_timer_nxt = '0;
          // Older queued events go first so ordering is preserved.
          if (r_pending != '0) begin
            w_take_pend = 1'b1;
            w_state_nxt = ST_HOLD;
          end else if (i_press) begin
            w_take_press = 1'b1;
            w_state_nxt  = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Pending counter: enqueue and dequeue in the same cycle cancel out, so a
  // full queue can still accept a press on the cycle one entry is consumed.
  always_comb begin
    w_add      = i_press & ~w_take_press;
    w_drop     = w_add & ~w_take_pend & (r_pending == PEND_MAX);
    w_pend_nxt = r_pending;
    if (w_add && !w_take_pend && (r_pending != PEND_MAX)) begin
      w_pend_nxt = r_pending + PEND_W'(1);
    end else if (!w_add && w_take_pend) begin
      w_pend_nxt = r_pending - PEND_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_pending  <= '0;
      r_level    <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_pending  <= w_pend_nxt;
      r_level    <= (w_state_nxt == ST_HOLD);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_overflow <= w_drop;
    end
  end

  assign o_level     = r_level;
  assign o_busy      = r_busy;
  assign o_pending   = r_pending;
  assign o_overflow  = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_press_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_press_pulse_stretcher
//   Bench for press_pulse_stretcher with HOLD_CYCLES=4, GAP_CYCLES=3, PEND_W=2.
//   Cycle 0 is the first cycle after reset release. Each cycle the expected
//   output vector {state, level, busy, pending, overflow} for the next cycle is
//   pushed when inputs are driven, and popped/compared one cycle later.
// -----------------------------------------------------------------------------
module tb_press_pulse_stretcher;

  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int PW   = 2;
  localparam int VW   = 7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic          clk;
  logic          rst;
  logic          press;
  logic          level;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int rand_p   = 5;

  logic [VW-1:0] exp_q[$];

  press_pulse_stretcher #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_press    (press),
    .o_level    (level),
    .o_busy     (busy),
    .o_pending  (pending),
    .o_overflow (overflow),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int cyc,
                          input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got {st,lvl,busy,pend,ovf}=%b expected %b",
               tag, cyc, got, exp);
    end
  endtask

  function automatic bit in_rng(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // ---------------- stimulus tables ----------------
  function automatic logic press_at(int t, int c);
    case (t)
      2: return c == 10;
      3: return (c == 10) || (c == 12);
      4: return in_rng(c, 10, 14);
      5: return (c == 10) || (c == 17);
      6: return (c == 10) || (c == 11);
      7: return c == rand_p;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rst_at(int t, int c);
    return (t == 6) && (c == 13);
  endfunction

  // Expected outputs during cycle c, written from the intended waveforms.
  function automatic logic [VW-1:0] exp_at(int t, int c);
    logic          lvl;
    logic          bsy;
    logic          ovf;
    logic [PW-1:0] pnd;
    logic [1:0]    st;
    lvl = 1'b0;
    bsy = 1'b0;
    ovf = 1'b0;
    pnd = '0;
    case (t)
      2: begin
        lvl = in_rng(c, 11, 14);
        bsy = in_rng(c, 11, 17);
      end
      3: begin
        lvl = in_rng(c, 11, 14) || in_rng(c, 18, 21);
        bsy = in_rng(c, 11, 24);
        pnd = in_rng(c, 13, 17) ? 2'd1 : 2'd0;
      end
      4: begin
        lvl = in_rng(c, 11, 14) || in_rng(c, 18, 21) ||
              in_rng(c, 25, 28) || in_rng(c, 32, 35);
        bsy = in_rng(c, 11, 38);
        if (c == 12)                pnd = 2'd1;
        else if (c == 13)           pnd = 2'd2;
        else if (in_rng(c, 14, 17)) pnd = 2'd3;
        else if (in_rng(c, 18, 24)) pnd = 2'd2;
        else if (in_rng(c, 25, 31)) pnd = 2'd1;
        ovf = (c == 15);
      end
      5: begin
        lvl = in_rng(c, 11, 14) || in_rng(c, 18, 21);
        bsy = in_rng(c, 11, 24);
      end
      6: begin
        lvl = in_rng(c, 11, 13);
        bsy = in_rng(c, 11, 13);
        pnd = in_rng(c, 12, 13) ? 2'd1 : 2'd0;
      end
      7: begin
        lvl = in_rng(c, rand_p + 1, rand_p + HOLD);
        bsy = in_rng(c, rand_p + 1, rand_p + HOLD + GAP);
      end
      default: ;
    endcase
    st = !bsy ? S_IDLE : (lvl ? S_HOLD : S_GAP);
    return {st, lvl, bsy, pnd, ovf};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic press_during);
    @(negedge clk);
    rst   = 1'b1;
    press = press_during;
    repeat (2) @(negedge clk);
    // Third reset cycle completes at the next posedge; cycle 0 starts after it.
  endtask

  task automatic run_test(input int t, input string tag, input int ncyc);
    logic [VW-1:0] e;
    exp_q.delete();
    exp_q.push_back(exp_at(t, 0));
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s cycle %0d: expected queue empty", tag, c);
      end else begin
        e = exp_q.pop_front();
        check_eq(tag, c, {dbg_state, level, busy, pending, overflow}, e);
      end
      if (c < ncyc) begin
        rst   = rst_at(t, c);
        press = press_at(t, c);
        exp_q.push_back(exp_at(t, c + 1));
      end
    end
    rst   = 1'b0;
    press = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst   = 1'b1;
    press = 1'b0;

    // 1: press held high through reset is discarded
    do_reset(1'b1);
    run_test(1, "reset_press_discard", 8);

    do_reset(1'b0);
    run_test(2, "single_press", 22);

    do_reset(1'b0);
    run_test(3, "queued_press", 28);

    do_reset(1'b0);
    run_test(4, "saturate_overflow", 42);

    do_reset(1'b0);
    run_test(5, "press_last_gap", 28);

    do_reset(1'b0);
    run_test(6, "reset_mid_pulse", 30);

    for (int k = 0; k < 3; k++) begin
      rand_p = $urandom_range(1, 9);
      do_reset(1'b0);
      run_test(7, "random_single", rand_p + HOLD + GAP + 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
